// File: rtl/rx_deint_pkg.sv
// rx_deint_pkg: shared state encoding, lane indices and width limits for rx_cic_deint.
package rx_deint_pkg;
    typedef enum logic {HUNT, COLLECT} state_t;
    localparam logic [1:0] CH_I0 = 2'd0;
    localparam logic [1:0] CH_Q0 = 2'd1;
    localparam logic [1:0] CH_I1 = 2'd2;
    localparam logic [1:0] CH_Q1 = 2'd3;
    localparam int OUT_W_MIN = 8;
    localparam int OUT_W_MAX = 24;
    localparam int DATA_W = 32;
endpackage

// File: rtl/rx_deint_scale.sv
// rx_deint_scale: gain shift with saturation of one CIC sample to an OUT_W lane.
// RX_DEINT_ROUND_EN selects round-half-up instead of floor before the shift.
module rx_deint_scale import rx_deint_pkg::*; #(
    parameter int OUT_W = 16
) (
    input  logic [DATA_W-1:0] in_data,
    input  logic [4:0]        gain_shift,
    output logic [OUT_W-1:0]  lane,
    output logic              ovf
);
    localparam int HEAD = DATA_W - OUT_W;
    localparam logic signed [DATA_W:0] MAX_V = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
    localparam logic signed [DATA_W:0] MIN_V = -(33'sd1 <<< (OUT_W - 1));
    logic [4:0] g, s;
    logic signed [DATA_W:0] x, v;
    always_comb begin
        g = (gain_shift > 5'(HEAD)) ? 5'(HEAD) : gain_shift;
        s = 5'(HEAD) - g;
`ifdef RX_DEINT_ROUND_EN
        x = {in_data[DATA_W-1], in_data} + ((s != 5'd0) ? (33'sd1 <<< (s - 5'd1)) : 33'sd0);
`else
        x = {in_data[DATA_W-1], in_data};
`endif
        v = x >>> s;
        ovf = (v > MAX_V) || (v < MIN_V);
        lane = (v > MAX_V) ? MAX_V[OUT_W-1:0] : (v < MIN_V) ? MIN_V[OUT_W-1:0] : v[OUT_W-1:0];
    end
endmodule

// File: rtl/rx_cic_deint.sv
// rx_cic_deint: deinterleaves the 4-channel CIC stream into scaled parallel frames
// with framing checks; RX_DEINT_ROUND_EN enables rounding in the lane scaler.
module rx_cic_deint import rx_deint_pkg::*; #(
    parameter int OUT_W = 16,
    parameter int ERR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_channel,
    input  logic              in_startofpacket,
    input  logic              in_endofpacket,
    input  logic [1:0]        in_error,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        gain_shift,
    output logic [OUT_W-1:0]  out_i0,
    output logic [OUT_W-1:0]  out_q0,
    output logic [OUT_W-1:0]  out_i1,
    output logic [OUT_W-1:0]  out_q1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_ovf,
    output logic [ERR_W-1:0]  err_cnt
);
    state_t state_q, state_d;
    logic [1:0] exp_q, exp_d;
    logic [2:0][OUT_W-1:0] buf_q, buf_d;
    logic [2:0] bovf_q, bovf_d;
    logic [3:0][OUT_W-1:0] out_q, out_d;
    logic oval_q, oval_d, oovf_q, oovf_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [OUT_W-1:0] lane_s;
    logic ovf_s, acc, start, good;

    rx_deint_scale #(.OUT_W(OUT_W)) u_scale (
        .in_data(in_data), .gain_shift(gain_shift), .lane(lane_s), .ovf(ovf_s)
    );

    always_comb begin
        in_ready = !(state_q == COLLECT && exp_q == CH_Q1 && oval_q && !out_ready);
        acc = in_valid && in_ready;
        start = in_error == 2'd0 && in_channel == CH_I0 && in_startofpacket;
        good = in_error == 2'd0 && in_channel == exp_q && !in_startofpacket
               && (in_endofpacket == (exp_q == CH_Q1));
        state_d = state_q;
        exp_d = exp_q;
        buf_d = buf_q;
        bovf_d = bovf_q;
        out_d = out_q;
        oval_d = oval_q && !out_ready;
        oovf_d = oovf_q;
        err_d = err_q;
        if (acc && state_q == HUNT) begin
            if (start) begin
                buf_d[0] = lane_s;
                bovf_d[0] = ovf_s;
                exp_d = CH_Q0;
                state_d = COLLECT;
            end
        end else if (acc && good) begin
            if (exp_q == CH_Q1) begin
                out_d = {lane_s, buf_q};
                oovf_d = ovf_s || (|bovf_q);
                oval_d = 1'b1;
                exp_d = CH_I0;
                state_d = HUNT;
            end else begin
                buf_d[exp_q] = lane_s;
                bovf_d[exp_q] = ovf_s;
                exp_d = exp_q + 2'd1;
            end
        end else if (acc) begin
            // A clean sop on ch0 is treated as the start of a new frame, not just dropped.
            err_d = (&err_q) ? err_q : err_q + ERR_W'(1);
            buf_d[0] = lane_s;
            bovf_d[0] = ovf_s;
            exp_d = start ? CH_Q0 : CH_I0;
            state_d = start ? COLLECT : HUNT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HUNT;
            exp_q <= CH_I0;
            buf_q <= '0;
            bovf_q <= '0;
            out_q <= '0;
            oval_q <= 1'b0;
            oovf_q <= 1'b0;
            err_q <= '0;
        end else begin
            state_q <= state_d;
            exp_q <= exp_d;
            buf_q <= buf_d;
            bovf_q <= bovf_d;
            out_q <= out_d;
            oval_q <= oval_d;
            oovf_q <= oovf_d;
            err_q <= err_d;
        end
    end

    assign out_i0 = out_q[0];
    assign out_q0 = out_q[1];
    assign out_i1 = out_q[2];
    assign out_q1 = out_q[3];
    assign out_valid = oval_q;
    assign out_ovf = oovf_q;
    assign err_cnt = err_q;
endmodule

// File: tb/tb_rx_cic_deint.sv
// tb_rx_cic_deint: directed vectors for scaling plus framing, backpressure and reset sequences.
module tb_rx_cic_deint;
    logic clk = 1'b0, reset_n = 1'b0;
    logic [31:0] in_data = '0;
    logic [1:0] in_channel = '0, in_error = '0;
    logic in_startofpacket = 1'b0, in_endofpacket = 1'b0, in_valid = 1'b0, in_ready;
    logic [4:0] gain_shift = '0;
    logic [15:0] out_i0, out_q0, out_i1, out_q1;
    logic out_valid, out_ready = 1'b1, out_ovf;
    logic [15:0] err_cnt;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    rx_cic_deint dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_channel(in_channel),
        .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
        .in_error(in_error), .in_valid(in_valid), .in_ready(in_ready),
        .gain_shift(gain_shift), .out_i0(out_i0), .out_q0(out_q0), .out_i1(out_i1),
        .out_q1(out_q1), .out_valid(out_valid), .out_ready(out_ready), .out_ovf(out_ovf),
        .err_cnt(err_cnt)
    );

    typedef struct {
        logic [4:0] g;
        logic [3:0][31:0] d;
        logic [3:0][15:0] e;
        logic ovf;
    } vec_t;

    function automatic vec_t mk(logic [4:0] g, logic [31:0] d0, d1, d2, d3,
                                logic [15:0] e0, e1, e2, e3, logic ovf);
        vec_t v;
        v.g = g;
        v.d = {d3, d2, d1, d0};
        v.e = {e3, e2, e1, e0};
        v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic put(logic [1:0] ch, logic [31:0] d, logic sop, logic eop, logic [1:0] err);
        int n = 0;
        @(negedge clk);
        in_channel = ch;
        in_data = d;
        in_startofpacket = sop;
        in_endofpacket = eop;
        in_error = err;
        in_valid = 1'b1;
        chk("in_ready", 32'(in_ready), 32'd1);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
    endtask

    task automatic frame(logic [4:0] g, logic [31:0] d0, d1, d2, d3);
        gain_shift = g;
        put(2'd0, d0, 1'b1, 1'b0, 2'd0);
        put(2'd1, d1, 1'b0, 1'b0, 2'd0);
        put(2'd2, d2, 1'b0, 1'b0, 2'd0);
        put(2'd3, d3, 1'b0, 1'b1, 2'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_out(string name, logic [15:0] e0, e1, e2, e3, logic ovf);
        chk({name, ".valid"}, 32'(out_valid), 32'd1);
        chk({name, ".i0"}, 32'(out_i0), 32'(e0));
        chk({name, ".q0"}, 32'(out_q0), 32'(e1));
        chk({name, ".i1"}, 32'(out_i1), 32'(e2));
        chk({name, ".q1"}, 32'(out_q1), 32'(e3));
        chk({name, ".ovf"}, 32'(out_ovf), 32'(ovf));
    endtask

    vec_t vt[6];

    initial begin
`ifdef RX_DEINT_ROUND_EN
        vt[0] = mk(5'd0, 32'h00012345, 32'hFFFEDCBB, 32'h00010000, 32'h0,
                   16'h0001, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
        vt[5] = mk(5'd0, 32'h00018000, 32'hFFFF8000, 32'h7FFFFFFF, 32'h80000000,
                   16'h0002, 16'h0000, 16'h7FFF, 16'h8000, 1'b1);
`else
        vt[0] = mk(5'd0, 32'h00012345, 32'hFFFEDCBB, 32'h00010000, 32'h0,
                   16'h0001, 16'hFFFE, 16'h0001, 16'h0000, 1'b0);
        vt[5] = mk(5'd0, 32'h00018000, 32'hFFFF8000, 32'h7FFFFFFF, 32'h80000000,
                   16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 1'b0);
`endif
        vt[1] = mk(5'd4, 32'h00012345, 32'h00012345, 32'h00012345, 32'h00012345,
                   16'h0012, 16'h0012, 16'h0012, 16'h0012, 1'b0);
        vt[2] = mk(5'd15, 32'h00012345, 32'h0, 32'h0, 32'h0,
                   16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        vt[3] = mk(5'd31, 32'h00012345, 32'hFFFF0000, 32'h00001234, 32'hFFFFFFFF,
                   16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF, 1'b1);
        vt[4] = mk(5'd16, 32'h00012345, 32'hFFFF0000, 32'h00001234, 32'hFFFFFFFF,
                   16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF, 1'b1);

        repeat (2) @(negedge clk);
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.i0", 32'(out_i0), 32'd0);
        chk("rst.q1", 32'(out_q1), 32'd0);
        chk("rst.ovf", 32'(out_ovf), 32'd0);
        chk("rst.err", 32'(err_cnt), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            frame(vt[i].g, vt[i].d[0], vt[i].d[1], vt[i].d[2], vt[i].d[3]);
            chk_out($sformatf("vec%0d", i), vt[i].e[0], vt[i].e[1], vt[i].e[2], vt[i].e[3], vt[i].ovf);
            chk($sformatf("vec%0d.err", i), 32'(err_cnt), 32'd0);
        end

        gain_shift = 5'd0;
        put(2'd0, 32'h00050000, 1'b1, 1'b0, 2'd0);
        put(2'd1, 32'h00060000, 1'b0, 1'b0, 2'd0);
        put(2'd3, 32'h00070000, 1'b0, 1'b1, 2'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("skip.err", 32'(err_cnt), 32'd1);
        chk("skip.valid", 32'(out_valid), 32'd0);
        frame(5'd0, 32'h00030000, 32'h00040000, 32'h00050000, 32'h00060000);
        chk_out("after_skip", 16'h3, 16'h4, 16'h5, 16'h6, 1'b0);
        chk("after_skip.err", 32'(err_cnt), 32'd1);

        gain_shift = 5'd4;
        put(2'd0, 32'h00011000, 1'b1, 1'b0, 2'd0);
        put(2'd1, 32'h00099000, 1'b0, 1'b0, 2'd0);
        put(2'd0, 32'h00022000, 1'b1, 1'b0, 2'd0);
        put(2'd1, 32'h00033000, 1'b0, 1'b0, 2'd0);
        put(2'd2, 32'h00044000, 1'b0, 1'b0, 2'd0);
        put(2'd3, 32'h00055000, 1'b0, 1'b1, 2'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("restart", 16'h22, 16'h33, 16'h44, 16'h55, 1'b0);
        chk("restart.err", 32'(err_cnt), 32'd2);

        put(2'd0, 32'h00011000, 1'b1, 1'b0, 2'd0);
        put(2'd1, 32'h00011000, 1'b0, 1'b0, 2'd0);
        put(2'd2, 32'h00011000, 1'b0, 1'b0, 2'b01);
        put(2'd3, 32'h00011000, 1'b0, 1'b1, 2'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("inerr.err", 32'(err_cnt), 32'd3);
        chk("inerr.valid", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        frame(5'd4, 32'h00011000, 32'h00022000, 32'h00033000, 32'h00044000);
        chk_out("bp.f1", 16'h11, 16'h22, 16'h33, 16'h44, 1'b0);
        put(2'd0, 32'h00055000, 1'b1, 1'b0, 2'd0);
        put(2'd1, 32'h00066000, 1'b0, 1'b0, 2'd0);
        put(2'd2, 32'h00077000, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        in_channel = 2'd3;
        in_data = 32'h00088000;
        in_startofpacket = 1'b0;
        in_endofpacket = 1'b1;
        chk("bp.stall0", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("bp.stall1", 32'(in_ready), 32'd0);
        chk_out("bp.hold", 16'h11, 16'h22, 16'h33, 16'h44, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("bp.release", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("bp.f2", 16'h55, 16'h66, 16'h77, 16'h88, 1'b0);
        @(negedge clk);
        chk("bp.drain", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        frame(5'd15, 32'h00012345, 32'h0, 32'h0, 32'h0);
        chk_out("pre_rst", 16'h7FFF, 16'h0, 16'h0, 16'h0, 1'b1);
        put(2'd0, 32'h00011000, 1'b1, 1'b0, 2'd0);
        put(2'd1, 32'h00011000, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst.valid", 32'(out_valid), 32'd0);
        chk("mid_rst.i0", 32'(out_i0), 32'd0);
        chk("mid_rst.ovf", 32'(out_ovf), 32'd0);
        chk("mid_rst.err", 32'(err_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        frame(5'd4, 32'h0000A000, 32'h0000B000, 32'h0000C000, 32'h0000D000);
        chk_out("post_rst", 16'hA, 16'hB, 16'hC, 16'hD, 1'b0);
        chk("post_rst.err", 32'(err_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
